// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and helpers for the data-memory responder
// Contents:
//   state_t      : responder FSM encoding (S_IDLE, S_WAIT, S_RESP)
//   DM_BASE_ADDR : default byte address of data-memory word 0
//   merge_be     : byte-lane merge of a store into an existing word
package mips_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [31:0] DM_BASE_ADDR = 32'h0000_0000;

  // Lane i of the result comes from wdata when be[i] is set, else from old_word.
  function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] m;
    m = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = wdata[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// rtl/dm_byte_ram.sv - 4-lane byte-enabled word RAM with synchronous clear
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous active-high, clears every word to 0
//   we    : write strobe for the word at addr
//   be    : byte-lane enables for the write (bit i = lane i)
//   addr  : word index
//   wdata : write data
//   rdata : asynchronous read of the word at addr
module dm_byte_ram
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= merge_be(mem[addr], wdata, be);
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory responder for the CPU load/store port
// One request at a time over req_valid/req_ready; after LATENCY wait cycles the
// captured access is performed and the result is held on rsp_* until
// rsp_valid & rsp_ready.
// Optional: define DM_TRACE_EN to print "@pc: *addr <= word" for every
// committed store.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   req_valid/ready : request handshake (ready only in IDLE)
//   req_we          : 1 = store, 0 = load
//   req_addr        : byte address
//   req_wdata       : store data
//   req_be          : store byte enables
//   req_pc          : issuing PC, used only for tracing
//   rsp_valid/ready : response handshake
//   rsp_rdata       : load data, 0 for stores and errors
//   rsp_err         : misaligned or out-of-range access
module dm_responder
  import mips_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = DM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            cap_we;
  logic [31:0]     cap_addr;
  logic [31:0]     cap_wdata;
  logic [3:0]      cap_be;

  // With LATENCY = 0 the access happens on the accept edge, so it must use the
  // live request; otherwise it uses the captured copy.
  logic            in_idle;
  logic            accept;
  logic            acc_we;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_be;
  logic [31:0]     off;
  logic            acc_err;
  logic            do_access;
  logic            ram_we;
  logic [31:0]     ram_rdata;
  logic            unused_bits;

  assign in_idle   = (state == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign acc_we    = in_idle ? req_we    : cap_we;
  assign acc_addr  = in_idle ? req_addr  : cap_addr;
  assign acc_wdata = in_idle ? req_wdata : cap_wdata;
  assign acc_be    = in_idle ? req_be    : cap_be;

  // Unsigned offset: addresses below BASE_ADDR wrap high and fail the range test.
  assign off       = acc_addr - BASE_ADDR;
  assign acc_err   = (|acc_addr[1:0]) | (|off[31:ADDR_WIDTH+2]);
  assign do_access = (LATENCY == 0) ? accept : ((state == S_WAIT) && (cnt == '0));
  assign ram_we    = do_access & acc_we & ~acc_err;

  dm_byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .be    (acc_be),
    .addr  (off[ADDR_WIDTH+1:2]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

`ifdef DM_TRACE_EN
  logic [31:0] cap_pc;
  logic [31:0] acc_pc;
  assign acc_pc      = in_idle ? req_pc : cap_pc;
  assign unused_bits = ^off[1:0];
`else
  assign unused_bits = ^{off[1:0], req_pc};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
`ifdef DM_TRACE_EN
      cap_pc    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
`ifdef DM_TRACE_EN
            cap_pc    <= req_pc;
`endif
            req_ready <= 1'b0;
            if (LATENCY != 0) begin
              cnt   <= CW'(LATENCY - 1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_RESP: begin
          // req_ready rises only after the handshake edge, so a new request
          // is never accepted in the handshake cycle.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (do_access) begin
        state     <= S_RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_we | acc_err) ? '0 : ram_rdata;
`ifdef DM_TRACE_EN
        if (ram_we)
          $display("@%h: *%h <= %h", acc_pc, {acc_addr[31:2], 2'b00},
                   merge_be(ram_rdata, acc_wdata, acc_be));
`endif
      end
    end
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder for the processor's load/store port; the memory end of the CPU's data access.
- Accepts one request at a time over a valid/ready handshake.
- Models a configurable access latency, applies byte-enabled writes and returns read data over a second valid/ready channel.
- Replaces the processor-internal data array so that later pipelined cores can stall on memory.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2^ADDR_WIDTH words (4 KiB default).
- LATENCY, 2, cycles spent in WAIT before the access completes (0 allowed).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables; bit i = byte lane i (little-endian lanes).
- req_pc  input  32  PC of the issuing instruction (trace only).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  misaligned or out-of-range access.

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is synchronous, active-high.
- Reset values:
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
  - Every memory word is cleared to 0 on reset.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready = 1. On req_valid & req_ready, capture we/addr/wdata/be/pc.
    - LATENCY = 0: go directly to RESP.
    - Otherwise: load counter = LATENCY-1 and go to WAIT.
  - WAIT: req_ready = 0; decrement the counter each cycle. When counter = 0, perform the access and go to RESP on the next edge.
  - RESP: rsp_valid = 1 and outputs held stable until rsp_valid & rsp_ready, then go to IDLE.
    - No new request is accepted in the same cycle as the handshake; back-to-back throughput is one access per LATENCY+2 cycles.
- Latency, accept edge to rsp_valid high: LATENCY+1 cycles (LATENCY=0 gives 1 cycle).
- Access semantics, evaluated on the captured request:
  - Error conditions:
    - Misaligned: addr[1:0] != 0 → rsp_err = 1.
    - Out of range: (addr - BASE_ADDR) >= 4·2^ADDR_WIDTH, unsigned → rsp_err = 1.
    - On error: no memory change, rsp_rdata = 0.
  - Store: for each i with be[i] = 1, mem[idx][8i+7:8i] = wdata[8i+7:8i]; other lanes are unchanged. be = 0 is a legal no-op store. rsp_rdata = 0.
  - Load: rsp_rdata = mem[idx] as the full word, regardless of be.
  - idx = (addr - BASE_ADDR)[ADDR_WIDTH+1:2].
- Memory is written exactly once per accepted store, at the edge leaving WAIT (or leaving IDLE when LATENCY = 0).
- Request-side signals are ignored while req_ready = 0; the requester holds them, but the captured copy is authoritative.
- Reset mid-operation (in WAIT or RESP): the access is aborted, an uncommitted store is never written, memory is cleared, and the FSM returns to IDLE.

Optional Feature:
- Macro: DM_TRACE_EN.
- Defined: on each committed store, emit "@%h: *%h <= %h" with captured pc, word-aligned address, and the merged word after the write. Erroneous accesses emit nothing.
- Undefined: no display output; req_pc is unused and optimised away.

Decomposition:
- Shared package `mips_mem_pkg`:
  - state encoding constants S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
  - byte-lane merge helper (function taking old word, wdata, be);
  - default BASE_ADDR.
- One sub-module is natural: `dm_byte_ram`, a depth-parameterised 4-lane byte-enabled RAM with synchronous clear-on-reset. The FSM and latency logic stay in dm_responder.

Test Plan:
- Reset then load addr 0x0000_0010 with LATENCY=2 → rsp_valid exactly 3 cycles after accept, rsp_rdata = 0x0000_0000, rsp_err = 0.
- Store 0x1234_5678 to 0x0000_0020 with be = 4'b1111, then store 0xAABB_CCDD with be = 4'b0101, then load → rsp_rdata = 0x12BB_56DD.
- Misaligned store to 0x0000_0022, then load 0x0000_0020 → store rsp_err = 1, memory unchanged. Out-of-range load 0x0000_1000 → rsp_err = 1, rsp_rdata = 0.
- Hold rsp_ready = 0 for 5 cycles during a load → rsp_valid and rsp_rdata stable; req_ready = 0 throughout; a new req_valid is not accepted until the cycle after the handshake.
- Assert reset in WAIT of a store of 0xDEAD_BEEF to 0x0000_0040, then load 0x0000_0040 → rsp_rdata = 0, state IDLE one cycle after reset.
- With DM_TRACE_EN and req_pc = 0x0000_3008, store 0x0000_0007 to 0x0000_0004 → exactly one line "@00003008: *00000004 <= 00000007". LATENCY = 0 rerun → rsp_valid 1 cycle after accept.
